// File: rtl/seg7_scan_driver.sv
// =============================================================================
// Module   : seg7_scan_driver
// Brief    : Time-multiplexed 8-digit common-anode seven-segment scan driver
//            with inter-digit blanking and frame-synchronous data commit.
// Revision : 1.0
// =============================================================================
`default_nettype none

module seg7_scan_driver #(
  parameter int DIGITS       = 8,
  parameter int DIV          = 10000,
  parameter int BLANK_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [4*DIGITS-1:0]   data_in,
  input  logic [DIGITS-1:0]     blank_in,
  input  logic                  load_in,
  output logic                  pending_out,
  output logic [DIGITS-1:0]     AN,
  output logic [6:0]            CATH,
  output logic                  frame_out
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [CNT_W-1:0]  C_LAST_CNT = CNT_W'(DIV - 1);
  localparam logic [IDX_W-1:0]  C_LAST_IDX = IDX_W'(DIGITS - 1);
  localparam logic [CNT_W-1:0]  C_BLANK    = CNT_W'(BLANK_CYCLES);
  localparam logic [6:0]        C_SEG_OFF  = 7'b1111111;
  localparam logic [DIGITS-1:0] C_ONE      = DIGITS'(1);

  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'b1000000;
      4'h1:    seg = 7'b1111001;
      4'h2:    seg = 7'b0100100;
      4'h3:    seg = 7'b0110000;
      4'h4:    seg = 7'b0011001;
      4'h5:    seg = 7'b0010010;
      4'h6:    seg = 7'b0000010;
      4'h7:    seg = 7'b1111000;
      4'h8:    seg = 7'b0000000;
      4'h9:    seg = 7'b0010000;
      4'hA:    seg = 7'b0001000;
      4'hB:    seg = 7'b0000011;
      4'hC:    seg = 7'b1000110;
      4'hD:    seg = 7'b0100001;
      4'hE:    seg = 7'b0000110;
      default: seg = 7'b0001110;
    endcase
    return seg;
  endfunction

  logic [CNT_W-1:0]    r_cnt;
  logic [IDX_W-1:0]    r_idx;
  logic [4*DIGITS-1:0] r_act_data;
  logic [DIGITS-1:0]   r_act_blank;
  logic [4*DIGITS-1:0] r_sh_data;
  logic [DIGITS-1:0]   r_sh_blank;
  logic                r_pending;

  logic                w_slot_end;
  logic                w_wrap;
  logic                w_gap;
  logic [IDX_W+1:0]    w_bit_sel;
  logic [3:0]          w_nibble;
  logic                w_digit_off;
  logic [DIGITS-1:0]   w_onehot;

  assign w_slot_end  = (r_cnt == C_LAST_CNT);
  assign w_wrap      = w_slot_end && (r_idx == C_LAST_IDX);
  assign w_gap       = (r_cnt < C_BLANK);
  assign w_bit_sel   = {r_idx, 2'b00};
  assign w_nibble    = r_act_data[w_bit_sel +: 4];
  assign w_digit_off = r_act_blank[r_idx];
  assign w_onehot    = C_ONE << r_idx;
  assign pending_out = r_pending;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt       <= '0;
      r_idx       <= '0;
      r_act_data  <= '0;
      r_act_blank <= '0;
      r_sh_data   <= '0;
      r_sh_blank  <= '0;
      r_pending   <= 1'b0;
      AN          <= '1;
      CATH        <= C_SEG_OFF;
      frame_out   <= 1'b0;
    end else begin
      r_cnt <= w_slot_end ? '0 : r_cnt + 1'b1;
      if (w_slot_end) begin
        r_idx <= (r_idx == C_LAST_IDX) ? '0 : r_idx + 1'b1;
      end

      frame_out <= w_wrap;

      // Commit uses the pre-edge shadow; a load on the same edge refills
      // the shadow afterwards and keeps pending set.
      if (w_wrap && r_pending) begin
        r_act_data  <= r_sh_data;
        r_act_blank <= r_sh_blank;
        r_pending   <= 1'b0;
      end
      if (load_in) begin
        r_sh_data  <= data_in;
        r_sh_blank <= blank_in;
        r_pending  <= 1'b1;
      end

      if (w_gap) begin
        AN   <= '1;
        CATH <= C_SEG_OFF;
      end else begin
        AN   <= w_digit_off ? '1 : ~w_onehot;
        CATH <= seg_decode(w_nibble);
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_seg7_scan_driver.sv
// =============================================================================
// Module   : tb_seg7_scan_driver
// Brief    : Directed self-checking bench for seg7_scan_driver (DIV=16).
// Revision : 1.0
// =============================================================================
`default_nettype none

module tb_seg7_scan_driver;

  localparam int DIGITS = 8;
  localparam int DIV    = 16;
  localparam int BLANK  = 2;
  localparam int FRAME  = DIGITS * DIV;

  logic        clk;
  logic        reset;
  logic [31:0] data_in;
  logic [7:0]  blank_in;
  logic        load_in;
  logic        pending_out;
  logic [7:0]  AN;
  logic [6:0]  CATH;
  logic        frame_out;

  int checks;
  int errors;
  int cyc;

  logic [6:0] dec [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                           7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                           7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                           7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  seg7_scan_driver #(
    .DIGITS      (DIGITS),
    .DIV         (DIV),
    .BLANK_CYCLES(BLANK)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .data_in    (data_in),
    .blank_in   (blank_in),
    .load_in    (load_in),
    .pending_out(pending_out),
    .AN         (AN),
    .CATH       (CATH),
    .frame_out  (frame_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Advance until the registered outputs reflect (slot, count) of the scan.
  task automatic go(input int slot, input int cnt);
    int target;
    int n;
    target = slot * DIV + cnt;
    n = 0;
    do begin
      tick();
      n++;
    end while ((((cyc - 1) % FRAME + FRAME) % FRAME) != target && n < 3 * FRAME);
    if (n >= 3 * FRAME) begin
      checks++;
      errors++;
      $error("FAIL go_timeout: observed %0d cycles expected < %0d", n, 3 * FRAME);
    end
  endtask

  task automatic load(input logic [31:0] d, input logic [7:0] b);
    data_in  = d;
    blank_in = b;
    load_in  = 1'b1;
    tick();
    load_in  = 1'b0;
  endtask

  function automatic logic [7:0] an_on(input int k);
    logic [7:0] one;
    one = 8'd1;
    return ~(one << k);
  endfunction

  initial begin
    checks   = 0;
    errors   = 0;
    cyc      = 0;
    reset    = 1'b1;
    data_in  = '0;
    blank_in = '0;
    load_in  = 1'b0;

    // Reset state
    repeat (3) tick();
    chk("rst_an",      AN,          32'hFF);
    chk("rst_cath",    CATH,        32'h7F);
    chk("rst_pending", pending_out, 32'h0);
    chk("rst_frame",   frame_out,   32'h0);
    reset = 1'b0;
    cyc   = 0;

    go(0, 1);
    chk("init_gap_an", AN, 32'hFF);
    go(0, 2);
    chk("init_s0_an",   AN,   32'hFE);
    chk("init_s0_cath", CATH, 32'b1000000);

    // Load 76543210 and watch the commit at the wrap
    load(32'h76543210, 8'h00);
    chk("ld1_pending", pending_out, 32'h1);
    go(7, 14);
    chk("ld1_pend_prewrap",  pending_out, 32'h1);
    chk("ld1_frame_prewrap", frame_out,   32'h0);
    go(7, 15);
    chk("ld1_frame_pulse",   frame_out,   32'h1);
    chk("ld1_pend_cleared",  pending_out, 32'h0);
    go(0, 0);
    chk("ld1_frame_single",  frame_out,   32'h0);
    chk("ld1_gap0_an",       AN,          32'hFF);
    for (int k = 0; k < DIGITS; k++) begin
      go(k, 1);
      chk($sformatf("f1_gap_an%0d", k), AN, 32'hFF);
      go(k, 2);
      chk($sformatf("f1_an%0d", k),   AN,   an_on(k));
      chk($sformatf("f1_cath%0d", k), CATH, dec[k]);
      go(k, 15);
      chk($sformatf("f1_cath_end%0d", k), CATH, dec[k]);
    end

    // Load with digits 0 and 7 blanked
    load(32'hFEDCBA98, 8'b1000_0001);
    go(7, 15);
    go(0, 2);
    chk("bl_s0_an_start", AN, 32'hFF);
    go(0, 15);
    chk("bl_s0_an_end",   AN, 32'hFF);
    go(1, 2);
    chk("bl_s1_an",   AN,   32'hFD);
    chk("bl_s1_cath", CATH, 32'b0010000);
    go(2, 2);
    chk("bl_s2_cath", CATH, 32'b0001000);
    go(6, 2);
    chk("bl_s6_an",   AN,   32'hBF);
    chk("bl_s6_cath", CATH, 32'b0000110);

    // Back-to-back loads in slot 7 of the frame just checked would be late;
    // use slot 3 of the following frame instead.
    go(7, 2);
    chk("bl_s7_an", AN, 32'hFF);
    go(3, 5);
    load(32'h11111111, 8'h00);
    load(32'h22222222, 8'h00);
    chk("mid_pending", pending_out, 32'h1);
    go(3, 10);
    chk("mid_s3_an",   AN,   32'hF7);
    chk("mid_s3_cath", CATH, 32'b0000011);
    go(5, 2);
    chk("mid_s5_cath", CATH, 32'b0100001);
    go(7, 2);
    chk("mid_s7_an",   AN,   32'hFF);
    for (int k = 0; k < DIGITS; k++) begin
      go(k, 2);
      chk($sformatf("two_an%0d", k),   AN,   an_on(k));
      chk($sformatf("two_cath%0d", k), CATH, 32'b0100100);
    end

    // Load on the wrap edge while a previous load is pending
    go(1, 5);
    load(32'h33333333, 8'h00);
    go(7, 14);
    data_in  = 32'h44444444;
    blank_in = 8'h00;
    load_in  = 1'b1;
    tick();
    load_in  = 1'b0;
    chk("col_frame",   frame_out,   32'h1);
    chk("col_pending", pending_out, 32'h1);
    go(0, 2);
    chk("col_s0_cath", CATH, 32'b0110000);
    go(7, 2);
    chk("col_s7_cath", CATH, 32'b0110000);
    go(7, 15);
    chk("col2_frame",   frame_out,   32'h1);
    chk("col2_pending", pending_out, 32'h0);
    go(0, 2);
    chk("col2_s0_cath", CATH, 32'b0011001);
    go(3, 2);
    chk("col2_s3_an",   AN,   32'hF7);
    chk("col2_s3_cath", CATH, 32'b0011001);

    // Reset in the middle of slot 5 with a load pending
    load(32'h55555555, 8'h00);
    go(5, 6);
    chk("mr_s5_an",   AN,   32'hDF);
    chk("mr_s5_cath", CATH, 32'b0011001);
    reset = 1'b1;
    tick();
    chk("mr_an",      AN,          32'hFF);
    chk("mr_cath",    CATH,        32'h7F);
    chk("mr_pending", pending_out, 32'h0);
    reset = 1'b0;
    cyc   = 0;
    go(0, 1);
    chk("mr_gap_an",  AN,   32'hFF);
    go(0, 2);
    chk("mr_s0_an",   AN,   32'hFE);
    chk("mr_s0_cath", CATH, 32'b1000000);
    go(7, 15);
    chk("mr_wrap_frame",   frame_out,   32'h1);
    chk("mr_wrap_pending", pending_out, 32'h0);
    go(4, 2);
    chk("mr_f2_s4_an",   AN,   32'hEF);
    chk("mr_f2_s4_cath", CATH, 32'b1000000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
